// File: rtl/bcd_pkg.sv
// Shared definitions for the debounced decimal-key to BCD encoder.
package bcd_pkg;
  localparam int NUM_KEYS = 10;
  localparam int BCD_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_EMIT,
    ST_WAIT_RELEASE
  } state_t;

  // OR of the indices of all set bits; exact for a one-hot input.
  function automatic logic [BCD_W-1:0] onehot_to_bcd(input logic [NUM_KEYS-1:0] oh);
    logic [BCD_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < NUM_KEYS; k++)
      if (oh[k]) idx = idx | BCD_W'(k);
    return idx;
  endfunction
endpackage

// File: rtl/bcd_key_sync.sv
// Parameterized-width 2-flop synchronizer with synchronous active-low clear.
module bcd_key_sync #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/bcd_key_encoder.sv
// Debounces ten one-hot key lines and offers one BCD digit per press on a
// valid/ready handshake; simultaneous presses raise a one-cycle error.
import bcd_pkg::*;

module bcd_key_encoder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] keys,
  output logic [BCD_W-1:0]    bcd_out,
  output logic                bcd_valid,
  input  logic                bcd_ready,
  output logic                multi_err,
  output logic                busy
);
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] w_ks;
  state_t              r_state, w_state;
  logic [NUM_KEYS-1:0] r_cap, w_cap;
  logic [7:0]          r_cnt, w_cnt;
  logic [BCD_W-1:0]    r_bcd, w_bcd;
  logic                r_valid, w_valid;
  logic                r_err, w_err;
  logic                w_onehot;

  bcd_key_sync #(.W(NUM_KEYS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (keys),
    .o_q   (w_ks)
  );

  // r_cap is never zero while in DEBOUNCE, so this is a true one-hot test there.
  assign w_onehot = (r_cap & (r_cap - NUM_KEYS'(1))) == '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cap   <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cap   <= w_cap;
      r_cnt   <= w_cnt;
      r_bcd   <= w_bcd;
      r_valid <= w_valid;
      r_err   <= w_err;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cap   = r_cap;
    w_cnt   = r_cnt;
    w_bcd   = r_bcd;
    w_valid = r_valid;
    w_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ks != '0) begin
          w_cap   = w_ks;
          w_cnt   = 8'd1;
          w_state = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (w_ks == '0) begin
          w_state = ST_IDLE;
        end else if (w_ks != r_cap) begin
          w_cap = w_ks;
          w_cnt = 8'd1;
        end else if (r_cnt == CNT_LAST) begin
          w_cnt = 8'd0;
          if (w_onehot) begin
            w_bcd   = onehot_to_bcd(r_cap);
            w_valid = 1'b1;
            w_state = ST_EMIT;
          end else begin
            w_err   = 1'b1;
            w_state = ST_WAIT_RELEASE;
          end
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      ST_EMIT: begin
        if (bcd_ready) begin
          w_valid = 1'b0;
          w_cnt   = 8'd0;
          w_state = ST_WAIT_RELEASE;
        end
      end
      ST_WAIT_RELEASE: begin
        if (w_ks != '0)            w_cnt   = 8'd0;
        else if (r_cnt == CNT_LAST) w_state = ST_IDLE;
        else                        w_cnt   = r_cnt + 8'd1;
      end
      default: w_state = ST_IDLE;
    endcase
  end

  assign bcd_out   = r_bcd;
  assign bcd_valid = r_valid;
  assign multi_err = r_err;
  assign busy      = (r_state != ST_IDLE);
endmodule
